// File: rtl/modulo_check_scheduler_if.sv
// Request/response handshake bundle for the shared mod-N checker.
// slave is the scheduler side; master is the requester/consumer side.
interface modulo_check_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2:0]               rsp_remainder;
    logic                     rsp_divisible;
    logic                     rsp_error;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
        input  rsp_remainder, rsp_divisible, rsp_error
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
        output rsp_remainder, rsp_divisible, rsp_error
    );
endinterface

// File: rtl/modulo_check_scheduler.sv
// Round-robin front end for a shared serial mod-N remainder engine,
// with a shadow remainder to cross-check the engine result.
module modulo_check_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int MODULUS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    modulo_check_scheduler_if.slave io,
    output logic                    eng_reset,
    output logic                    eng_bit,
    input  logic [2:0]              eng_remainder,
    output logic                    busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SAMPLE,
        RESPOND
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  id_q;
    logic [ID_W:0]    scan;
    logic             found;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;
    logic [2:0]       shadow_next;
    logic [3:0]       shadow_sum;

    // First valid requester at or after the pointer, wrapping upward.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ))
                scan = scan - (ID_W+1)'(NUM_REQ);
            if (!found && io.req_valid[scan[ID_W-1:0]]) begin
                found = 1'b1;
                win   = scan[ID_W-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && found;

    always_comb begin
        io.req_ready = '0;
        if (accept)
            io.req_ready[win] = 1'b1;
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = SAMPLE;
            SAMPLE:  state_next = RESPOND;
            RESPOND: if (io.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    assign busy         = (state != IDLE);
    assign eng_reset    = (state != SHIFT);
    assign eng_bit      = (state == SHIFT) && sreg[WIDTH-1];
    assign io.rsp_valid = (state == RESPOND);

    // 2*s + b stays below 2*MODULUS, so one conditional subtract suffices.
    assign shadow_sum  = {shadow, 1'b0} + {3'b000, eng_bit};
    assign shadow_next = 3'((shadow_sum >= 4'(MODULUS))
                            ? (shadow_sum - 4'(MODULUS))
                            : shadow_sum);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr              <= '0;
            id_q             <= '0;
            sreg             <= '0;
            cnt              <= '0;
            shadow           <= '0;
            io.rsp_id        <= '0;
            io.rsp_remainder <= '0;
            io.rsp_divisible <= 1'b0;
            io.rsp_error     <= 1'b0;
        end else begin
            if (accept) begin
                sreg   <= WIDTH'(io.req_data >> (int'(win) * WIDTH));
                id_q   <= win;
                cnt    <= '0;
                shadow <= '0;
                ptr    <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (state == SHIFT) begin
                sreg   <= sreg << 1;
                cnt    <= cnt + 1'b1;
                shadow <= shadow_next;
            end
            if (state == SAMPLE) begin
                io.rsp_remainder <= eng_remainder;
                io.rsp_divisible <= (eng_remainder == 3'd0);
                io.rsp_error     <= (eng_remainder != shadow);
                io.rsp_id        <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_modulo_check_scheduler.sv
// Directed plus randomized bench for modulo_check_scheduler with an
// arithmetic reference model and a behavioural serial engine.
module tb_modulo_check_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int MODULUS = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       eng_reset;
    logic       eng_bit;
    logic       busy;
    logic [2:0] eng_remainder;
    logic [2:0] eng_acc   = 3'd0;
    bit         force_en  = 1'b0;
    logic [2:0] force_val = 3'd0;
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         ptr_m     = 0;

    modulo_check_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    modulo_check_scheduler #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io           (bus),
        .eng_reset    (eng_reset),
        .eng_bit      (eng_bit),
        .eng_remainder(eng_remainder),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock)
        eng_acc <= eng_reset ? 3'd0
                 : 3'((int'(eng_acc) * 2 + int'(eng_bit)) % MODULUS);

    assign eng_remainder = force_en ? force_val : eng_acc;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i = (ptr_m + k) % NUM_REQ;
            if (((v >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    // Waits for acceptance, follows the word through to the response,
    // and leaves the bench at the first RESPOND sample point.
    task automatic serve(input string tag, output int gid, output int t_acc);
        int               n;
        int               exp_id;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] seen;
        logic [2:0]       true_rem;
        logic [2:0]       exp_rem;
        gid   = -1;
        t_acc = cyc;
        n     = 0;
        #1;
        while (((bus.req_ready & bus.req_valid) == '0) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $error("FAIL %s_accept got=none exp=grant", tag);
            return;
        end
        exp_id = pick(bus.req_valid);
        check({tag, "_grant"}, 64'(bus.req_ready), 64'(1) << exp_id);
        gid      = exp_id;
        t_acc    = cyc;
        w        = WIDTH'(bus.req_data >> (exp_id * WIDTH));
        ptr_m    = (exp_id + 1) % NUM_REQ;
        true_rem = 3'(w % WIDTH'(MODULUS));
        exp_rem  = force_en ? force_val : true_rem;
        seen     = '0;
        for (int b = 0; b < WIDTH; b++) begin
            step();
            if (b == 0) begin
                check({tag, "_ready_drop"}, 64'(bus.req_ready), 64'(0));
                check({tag, "_eng_reset_shift"}, 64'(eng_reset), 64'(0));
            end
            seen = {seen[WIDTH-2:0], eng_bit};
        end
        check({tag, "_bits"}, 64'(seen), 64'(w));
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - t_acc), 64'(WIDTH + 2));
        check({tag, "_id"}, 64'(bus.rsp_id), 64'(exp_id));
        check({tag, "_rem"}, 64'(bus.rsp_remainder), 64'(exp_rem));
        check({tag, "_div"}, 64'(bus.rsp_divisible), 64'(exp_rem == 3'd0));
        check({tag, "_err"}, 64'(bus.rsp_error), 64'(exp_rem != true_rem));
    endtask

    initial begin
        int         g;
        int         t;
        int         t_prev;
        int         cnt_v;
        logic [1:0] s_id;
        logic [2:0] s_rem;
        logic       s_div;
        logic       s_err;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'(0));
        check("rst_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_id", 64'(bus.rsp_id), 64'(0));
        check("rst_rem", 64'(bus.rsp_remainder), 64'(0));
        check("rst_div", 64'(bus.rsp_divisible), 64'(0));
        check("rst_err", 64'(bus.rsp_error), 64'(0));
        check("rst_eng_reset", 64'(eng_reset), 64'(1));
        check("rst_eng_bit", 64'(eng_bit), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // Word 25 on requester 0
        bus.req_data[0*WIDTH +: WIDTH] = 16'd25;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        serve("w25", g, t);
        bus.req_valid = '0;
        step();
        check("w25_idle_busy", 64'(busy), 64'(0));
        check("w25_idle_valid", 64'(bus.rsp_valid), 64'(0));

        // Word 1234 on requester 2
        bus.req_data[2*WIDTH +: WIDTH] = 16'd1234;
        bus.req_valid = 4'b0100;
        serve("w1234", g, t);
        bus.req_valid = '0;
        step();

        // Fresh pointer, all requesters persistent
        reset = 1'b1;
        step();
        reset = 1'b0;
        ptr_m = 0;
        bus.req_data  = {$urandom(), $urandom()};
        bus.req_valid = 4'b1111;
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            serve("rr", g, t);
            check("rr_order", 64'(g), 64'(i % NUM_REQ));
            if (i > 0)
                check("rr_spacing", 64'(t - t_prev), 64'(WIDTH + 3));
            t_prev = t;
        end
        bus.req_valid = '0;
        step();

        // Back-pressure on the response channel
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        serve("stall", g, t);
        s_id  = bus.rsp_id;
        s_rem = bus.rsp_remainder;
        s_div = bus.rsp_divisible;
        s_err = bus.rsp_error;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", 64'(bus.rsp_valid), 64'(1));
            check("stall_id", 64'(bus.rsp_id), 64'(s_id));
            check("stall_rem", 64'(bus.rsp_remainder), 64'(s_rem));
            check("stall_div", 64'(bus.rsp_divisible), 64'(s_div));
            check("stall_err", 64'(bus.rsp_error), 64'(s_err));
            check("stall_ready", 64'(bus.req_ready), 64'(0));
            check("stall_busy", 64'(busy), 64'(1));
        end
        bus.rsp_ready = 1'b1;
        step();
        check("stall_release_valid", 64'(bus.rsp_valid), 64'(0));
        check("stall_release_busy", 64'(busy), 64'(0));
        bus.req_valid = '0;

        // Reset in the middle of SHIFT
        bus.req_data[0*WIDTH +: WIDTH] = 16'($urandom());
        bus.req_valid = 4'b0001;
        #1;
        check("mid_grant", 64'(bus.req_ready), 64'(1));
        step();
        bus.req_valid = '0;
        repeat (6) step();
        check("mid_in_shift", 64'(eng_reset), 64'(0));
        reset = 1'b1;
        step();
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_eng_reset", 64'(eng_reset), 64'(1));
        check("mid_valid", 64'(bus.rsp_valid), 64'(0));
        reset = 1'b0;
        ptr_m = 0;
        cnt_v = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.rsp_valid !== 1'b0) cnt_v++;
        end
        check("mid_no_rsp", 64'(cnt_v), 64'(0));
        bus.req_valid = 4'b1001;
        serve("post_rst", g, t);
        check("post_rst_winner", 64'(g), 64'(0));
        bus.req_valid = '0;
        step();

        // Faulty engine reports
        force_en  = 1'b1;
        force_val = 3'd3;
        bus.req_data[0*WIDTH +: WIDTH] = 16'd25;
        bus.req_valid = 4'b0001;
        serve("bad3", g, t);
        bus.req_valid = '0;
        step();
        force_val = 3'd7;
        bus.req_valid = 4'b0001;
        serve("bad7", g, t);
        bus.req_valid = '0;
        step();
        force_en = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 8; i++) begin
            bus.req_data  = {$urandom(), $urandom()};
            bus.req_valid = 4'($urandom_range(1, 15));
            serve("rand", g, t);
        end
        bus.req_valid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/modulo_check_scheduler.md
Name: modulo_check_scheduler

Overview:
- Shares one serial mod-5 remainder engine among NUM_REQ requesters.
- Each requester submits a WIDTH-bit word over a valid/ready handshake. The block grants requesters round-robin and streams the word MSB-first into the engine, one bit per clock.
- It samples the engine's final remainder and returns it with the requester ID over a valid/ready response channel.
- A shadow remainder computed inside the block cross-checks the engine result.

Parameters:
- NUM_REQ, default 4: number of requesters (2..8).
- WIDTH, default 16: bits per submitted word (2..32).
- MODULUS, default 5: divisor implemented by the engine; remainder width is fixed at 3 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*WIDTH  requester i word in bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; a word is accepted when req_valid[i] and req_ready[i] are both high
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  clog2(NUM_REQ)  index of the served requester
- rsp_remainder  out  3  engine remainder for the word
- rsp_divisible  out  1  high when rsp_remainder == 0
- rsp_error  out  1  engine remainder differs from the shadow remainder
- eng_reset  out  1  engine clear; the engine takes remainder 0 on a clock edge where this is high
- eng_bit  out  1  serial bit to the engine
- eng_remainder  in  3  engine current remainder
- busy  out  1  high when the state is not IDLE

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer 0.
  - req_ready 0, rsp_valid 0, rsp_id 0, rsp_remainder 0, rsp_divisible 0, rsp_error 0.
  - eng_reset 1, eng_bit 0, busy 0.
- State machine: IDLE -> SHIFT -> SAMPLE -> RESPOND -> IDLE.
- IDLE:
  - eng_reset = 1.
  - If any req_valid is high, req_ready is driven combinationally one-hot to the winner. The winner is the first valid requester at or after the pointer, scanning upward with wrap.
  - On acceptance:
    - Load req_data of the winner into the shift register.
    - Latch the winner's ID.
    - Clear the bit counter and the shadow remainder.
    - Set pointer = (winner + 1) mod NUM_REQ.
    - Go to SHIFT.
  - With no req_valid, req_ready stays 0 and the pointer is unchanged.
- SHIFT (exactly WIDTH cycles):
  - eng_reset = 0.
  - eng_bit = shift register MSB; the register shifts left each cycle.
  - Shadow remainder: s <= (2*s + eng_bit) mod MODULUS.
  - After WIDTH bits, go to SAMPLE.
- SAMPLE (1 cycle):
  - eng_reset = 1.
  - At the leaving edge, register: rsp_remainder <= eng_remainder; rsp_divisible <= (eng_remainder == 0); rsp_error <= (eng_remainder != s); rsp_id <= latched ID.
  - Go to RESPOND.
- RESPOND:
  - rsp_valid = 1; all response fields are held stable.
  - eng_reset = 1; req_ready = 0.
  - On rsp_valid and rsp_ready, drop rsp_valid and go to IDLE.
- Latency:
  - Acceptance edge at cycle k; SHIFT occupies cycles k+1 .. k+WIDTH; SAMPLE is cycle k+WIDTH+1; rsp_valid is high from cycle k+WIDTH+2.
  - Minimum spacing between acceptances is WIDTH+3 cycles.
- Boundary conditions:
  - Requesters may deassert req_valid without being served. No state is kept for unserved requests.
  - rsp_ready high in the first RESPOND cycle completes the response in one cycle.
  - rsp_ready low for any duration stalls the block; no new acceptance occurs.
  - Pointer wrap: after granting NUM_REQ-1, the pointer returns to 0.
  - A single persistent requester is served on every IDLE visit.
  - Reset at any point has priority: the in-flight word is discarded, no response is produced, and all reset values are restored on the next edge.
  - An out-of-range eng_remainder (>= MODULUS) is passed through unchanged and flags rsp_error.

Test Plan:
- req_valid[0] = 1 with word 25 -> req_ready[0] high 1 cycle; rsp_valid asserts 18 cycles after acceptance with rsp_id = 0, rsp_remainder = 0, rsp_divisible = 1, rsp_error = 0.
- req_valid[2] with word 1234 and a correct engine model -> rsp_id = 2, rsp_remainder = 4, rsp_divisible = 0; eng_bit sequence equals 1234 MSB-first over 16 cycles.
- All four req_valid held high with rsp_ready = 1 -> grant order 0,1,2,3,0,1 with acceptances 19 cycles apart.
- rsp_ready low for 10 cycles in RESPOND -> rsp_valid and all fields stable, req_ready = 0, busy = 1; rsp_ready high -> IDLE on the next cycle.
- Reset asserted at SHIFT cycle 7 -> next cycle: busy = 0, eng_reset = 1, rsp_valid never asserts; a fresh req_valid[3] with req_valid[0] both high grants 0 (pointer back to 0).
- Engine model forced to report 3 for word 25 -> rsp_remainder = 3, rsp_divisible = 0, rsp_error = 1.
